// File: rtl/dense_layer_engine.sv
// dense_layer_engine: time-multiplexed fully connected layer (float32) sharing one multiplier and one adder
// across all neurons, with run-time activation (identity, ReLU, leaky ReLU) and register-written weights.
module dense_layer_engine #(
   parameter int N_IN       = 2,
   parameter int N_OUT      = 3,
   parameter int MUL_LAT    = 3,
   parameter int ADD_LAT    = 3,
   parameter int LEAK_SHIFT = 3,
   parameter int AW         = $clog2(N_OUT*(N_IN+1))
)(
   input  logic                clk,
   input  logic                reset,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [31:0]         wr_data,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [32*N_IN-1:0]  in_data,
   input  logic [1:0]          act_mode,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [32*N_OUT-1:0] out_data,
   output logic                busy
);
   localparam int NP = N_OUT*(N_IN+1);
   localparam int IW = N_IN  > 1 ? $clog2(N_IN)  : 1;
   localparam int JW = N_OUT > 1 ? $clog2(N_OUT) : 1;
   typedef enum logic [2:0] {S_IDLE, S_MUL, S_ADD, S_ACT, S_DONE} state_t;

   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic        s, g, st;
      logic [47:0] p;
      logic [23:0] m;
      logic [24:0] r;
      int          e;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'hff || b[30:23] == 8'hff) begin
         if (a[30:0] > 31'h7f800000 || b[30:0] > 31'h7f800000 || a[30:23] == 8'd0 || b[30:23] == 8'd0)
            return 32'h7fc00000;
         return {s, 8'hff, 23'd0};
      end
      // denormals are flushed to signed zero
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
      p  = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      e  = int'(a[30:23]) + int'(b[30:23]) - 127 + int'(p[47]);
      m  = p[47] ? p[47:24] : p[46:23];
      g  = p[47] ? p[23] : p[22];
      st = p[47] ? |p[22:0] : |p[21:0];
      r  = {1'b0, m} + 25'(g && (st || m[0]));
      if (r[24]) begin
         e++;
         r = r >> 1;
      end
      if (e >= 255) return {s, 8'hff, 23'd0};
      if (e <= 0) return {s, 31'd0};
      return {s, e[7:0], r[22:0]};
   endfunction

   function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
      logic [31:0] x, y;
      logic [7:0]  d;
      logic [49:0] mx, my, sh;
      logic [50:0] sum;
      logic [24:0] r;
      logic        g, st;
      int          e, lz;
      if (a[30:23] == 8'hff) return (b[30:23] == 8'hff && a != b) ? 32'h7fc00000 : a;
      if (b[30:23] == 8'hff) return b;
      if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? {a[31] & b[31], 31'd0} : b;
      if (b[30:23] == 8'd0) return a;
      {x, y} = (a[30:0] >= b[30:0]) ? {a, b} : {b, a};
      d  = x[30:23] - y[30:23];
      mx = {1'b1, x[22:0], 26'd0};
      my = {1'b1, y[22:0], 26'd0};
      sh = my >> d;
      if (d > 8'd49) sh = 50'd1;
      else if ((sh << d) != my) sh[0] = 1'b1;
      sum = (x[31] == y[31]) ? {1'b0, mx} + {1'b0, sh} : {1'b0, mx} - {1'b0, sh};
      if (sum == 51'd0) return 32'd0;
      lz = 0;
      for (int k = 0; k < 51; k++) if (sum[k]) lz = 50 - k;
      sum = sum << lz;
      e   = int'(x[30:23]) + 1 - lz;
      g   = sum[26];
      st  = |sum[25:0];
      r   = {2'b01, sum[49:27]} + 25'(g && (st || sum[27]));
      if (r[24]) begin
         e++;
         r = r >> 1;
      end
      if (e >= 255) return {x[31], 8'hff, 23'd0};
      if (e <= 0) return {x[31], 31'd0};
      return {x[31], e[7:0], r[22:0]};
   endfunction

   function automatic logic [31:0] act(input logic [31:0] a, input logic [1:0] m);
      if (m == 2'd1) return a[31] ? 32'd0 : a;
      if (m == 2'd2 && a[31] && a[30:23] != 8'hff)
         return (int'(a[30:23]) <= LEAK_SHIFT) ? 32'd0 : {a[31], a[30:23] - 8'(LEAK_SHIFT), a[22:0]};
      return a;
   endfunction

   state_t      r_state;
   logic [7:0]  r_cnt;
   logic [IW-1:0] r_i;
   logic [JW-1:0] r_j;
   logic [1:0]  r_mode;
   logic [31:0] r_acc, r_prod;
   logic [31:0] r_x   [N_IN];
   logic [31:0] r_prm [NP];
   logic [31:0] r_y   [N_OUT];
   logic        r_in_ready, r_out_valid, r_busy;
   logic [31:0] w_prod, w_sum;

   // FPU operands stay stable for the whole latency window; the counter marks the sample cycle
   assign w_prod    = fmul(r_x[r_i], r_prm[AW'(int'(r_j)*N_IN + int'(r_i))]);
   assign w_sum     = fadd(r_acc, r_prod);
   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

   genvar g;
   generate
      for (g = 0; g < N_OUT; g++) begin : g_pack
         assign out_data[32*g +: 32] = r_y[g];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NP; k++) r_prm[k] <= '0;
      end else if (wr_en && !r_busy && int'(wr_addr) < NP) begin
         r_prm[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_i         <= '0;
         r_j         <= '0;
         r_mode      <= '0;
         r_acc       <= '0;
         r_prod      <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         for (int k = 0; k < N_IN; k++) r_x[k] <= '0;
         for (int k = 0; k < N_OUT; k++) r_y[k] <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (in_valid && r_in_ready) begin
               for (int k = 0; k < N_IN; k++) r_x[k] <= in_data[32*k +: 32];
               r_mode     <= act_mode;
               r_i        <= '0;
               r_j        <= '0;
               r_cnt      <= '0;
               r_in_ready <= 1'b0;
               r_busy     <= 1'b1;
               r_state    <= S_MUL;
            end
            S_MUL: if (r_cnt == 8'(MUL_LAT-1)) begin
               r_prod  <= w_prod;
               // bias is read here so a write landing on the capture edge is seen
               if (r_i == '0) r_acc <= r_prm[AW'(N_OUT*N_IN + int'(r_j))];
               r_cnt   <= '0;
               r_state <= S_ADD;
            end else r_cnt <= r_cnt + 8'd1;
            S_ADD: if (r_cnt == 8'(ADD_LAT-1)) begin
               r_acc   <= w_sum;
               r_cnt   <= '0;
               r_i     <= (int'(r_i) == N_IN-1) ? r_i : r_i + IW'(1);
               r_state <= (int'(r_i) == N_IN-1) ? S_ACT : S_MUL;
            end else r_cnt <= r_cnt + 8'd1;
            S_ACT: begin
               r_y[r_j] <= act(r_acc, r_mode);
               r_i      <= '0;
               r_j      <= (int'(r_j) == N_OUT-1) ? r_j : r_j + JW'(1);
               r_state  <= (int'(r_j) == N_OUT-1) ? S_DONE : S_MUL;
            end
            S_DONE: if (!r_out_valid) r_out_valid <= 1'b1;
            else if (out_ready) begin
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_dense_layer_engine.sv
// tb_dense_layer_engine: directed vectors with hand-computed float results for the default
// 2-input, 3-neuron configuration.
module tb_dense_layer_engine;
   localparam logic [31:0] ONE = 32'h3F800000, TWO = 32'h40000000, HALF = 32'h3F000000;
   localparam logic [31:0] M8 = 32'hC1000000, M7 = 32'hC0E00000;

   logic        clk = 1'b0, reset = 1'b1, wr_en = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [63:0] in_data = '0;
   logic [1:0]  act_mode = '0;
   logic        in_ready, out_valid, busy;
   logic [95:0] out_data;
   int          checks = 0, failures = 0, cyc;

   dense_layer_engine dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .act_mode(act_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
   endtask

   task automatic start(input logic [31:0] x0, input logic [31:0] x1, input logic [1:0] m,
                        input logic we = 1'b0, input logic [3:0] wa = 4'd0, input logic [31:0] wd = 32'd0);
      int n = 0;
      in_data = {x1, x0}; act_mode = m; in_valid = 1'b1;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("in_ready_before_capture", in_ready, 1);
      wr_en = we; wr_addr = wa; wr_data = wd;
      @(posedge clk); #1;
      in_valid = 1'b0; wr_en = 1'b0;
      chk("busy_after_capture", busy, 1);
      chk("in_ready_after_capture", in_ready, 0);
   endtask

   task automatic wait_out(output int c);
      c = 0;
      while (!out_valid && c < 200) begin
         @(posedge clk); #1;
         c++;
      end
   endtask

   task automatic hs();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("hs_in_ready", in_ready, 1);
      chk("hs_out_valid", out_valid, 0);
      chk("hs_busy", busy, 0);
   endtask

   task automatic run(input string tag, input logic [1:0] m, input logic [95:0] exp);
      start(ONE, ONE, m);
      wait_out(cyc);
      chk({tag, "_latency"}, 96'(cyc), 96'd40);
      chk(tag, out_data, exp);
      hs();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_out_data", out_data, 0);
      reset = 1'b0;
      for (int j = 0; j < 3; j++) begin
         wr(2*j, TWO); wr(2*j+1, HALF); wr(6+j, ONE);
      end
      run("relu_pos", 2'd1, {3{32'h40600000}});
      for (int j = 0; j < 3; j++) wr(6+j, M8);
      // -8 + 2 + 0.5 = -5.5
      run("neg_relu", 2'd1, 96'd0);
      run("neg_ident", 2'd0, {3{32'hC0B00000}});
      run("neg_leaky", 2'd2, {3{32'hBF300000}});
      run("neg_mode3", 2'd3, {3{32'hC0B00000}});
      for (int j = 0; j < 3; j++) wr(6+j, M7);
      run("m45_ident", 2'd0, {3{32'hC0900000}});
      run("m45_leaky", 2'd2, {3{32'hBF100000}});
      wr(6, ONE); wr(7, M8); wr(8, 32'd0);
      run("per_neuron", 2'd1, {32'h40200000, 32'h0, 32'h40600000});
      start(ONE, ONE, 2'd1);
      wait_out(cyc);
      chk("bp_latency", 96'(cyc), 96'd40);
      in_valid = 1'b1; in_data = {M8, M8};
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         chk("bp_data", out_data, {32'h40200000, 32'h0, 32'h40600000});
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
      end
      in_valid = 1'b0;
      hs();
      start(ONE, ONE, 2'd1);
      repeat (4) @(posedge clk);
      #1;
      wr(6, M8);
      wait_out(cyc);
      chk("busy_wr_latency", 96'(cyc), 96'd35);
      chk("busy_wr_dropped", out_data, {32'h40200000, 32'h0, 32'h40600000});
      hs();
      wr(6, M8);
      run("idle_wr", 2'd1, {32'h40200000, 32'h0, 32'h0});
      start(ONE, ONE, 2'd1, 1'b1, 4'd8, ONE);
      wait_out(cyc);
      chk("cap_wr_latency", 96'(cyc), 96'd40);
      chk("cap_wr", out_data, {32'h40600000, 32'h0, 32'h0});
      hs();
      for (int k = 0; k < 6; k++) wr(k, 32'd0);
      wr(6, 32'h81000000); wr(7, 32'h82000000); wr(8, 32'hFF800000);
      run("leaky_edges", 2'd2, {32'hFF800000, 32'h80800000, 32'h0});
      run("relu_edges", 2'd1, 96'd0);
      run("ident_edges", 2'd0, {32'hFF800000, 32'h82000000, 32'h81000000});
      start(ONE, ONE, 2'd0);
      repeat (19) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_out_data", out_data, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      run("post_rst_ident", 2'd0, 96'd0);
      run("post_rst_relu", 2'd1, 96'd0);
      run("post_rst_leaky", 2'd2, 96'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
